// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding and one-hot decode.
package sdram_arb_pkg;
  localparam int MAX_PORTS = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin picker; SDRAM_ARB_PRIO0_EN gives port 0 absolute priority.
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS = 3
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NPORTS-1:0] winner,
  output logic              valid
);

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
`ifdef SDRAM_ARB_PRIO0_EN
    if (req[0]) begin
      winner[0] = 1'b1;
      valid     = 1'b1;
    end
`endif
    // Scan upward from last+1 with wrap; the first hit wins.
    for (int i = 1; i <= NPORTS; i++) begin
      idx = (int'(last) + i) % NPORTS;
`ifdef SDRAM_ARB_PRIO0_EN
      if (!valid && idx != 0 && req[idx]) begin
`else
      if (!valid && req[idx]) begin
`endif
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port among NPORTS requesters (IDLE/BUSY/ACK FSM).
// Optional build macro SDRAM_ARB_PRIO0_EN: port 0 (video) overrides round-robin.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS     = 3,
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_in,
  input  logic [NPORTS-1:0]            port_req,
  input  logic [NPORTS-1:0]            port_wr,
  input  logic [NPORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NPORTS*DATA_WIDTH-1:0] port_wdata,
  output logic [NPORTS-1:0]            port_ack,
  output logic [DATA_WIDTH-1:0]        port_rdata,
  output logic [NPORTS-1:0]            grant,
  output logic                         ctl_req,
  output logic                         ctl_wr,
  output logic [ADDR_WIDTH-1:0]        ctl_addr,
  output logic [DATA_WIDTH-1:0]        ctl_wdata,
  input  logic                         ctl_ack,
  input  logic [DATA_WIDTH-1:0]        ctl_rdata
);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [NPORTS-1:0]     grant_q, grant_d;
  logic [NPORTS-1:0]     port_ack_q, port_ack_d;
  logic [DATA_WIDTH-1:0] port_rdata_q, port_rdata_d;
  logic                  ctl_req_q, ctl_req_d;
  logic                  ctl_wr_q, ctl_wr_d;
  logic [ADDR_WIDTH-1:0] ctl_addr_q, ctl_addr_d;
  logic [DATA_WIDTH-1:0] ctl_wdata_q, ctl_wdata_d;

  logic [NPORTS-1:0]     win;
  logic                  win_vld;
  logic [MAX_PORTS-1:0]  win_ext;
  logic [IDX_W-1:0]      win_idx;

  rr_pick #(.NPORTS(NPORTS)) u_pick (
    .req    (port_req),
    .last   (last_q),
    .winner (win),
    .valid  (win_vld)
  );

  always_comb begin
    win_ext              = '0;
    win_ext[NPORTS-1:0]  = win;
    win_idx              = onehot_to_idx(win_ext);
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    port_ack_d   = port_ack_q;
    port_rdata_d = port_rdata_q;
    ctl_req_d    = ctl_req_q;
    ctl_wr_d     = ctl_wr_q;
    ctl_addr_d   = ctl_addr_q;
    ctl_wdata_d  = ctl_wdata_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d     = win;
          ctl_req_d   = 1'b1;
          ctl_wr_d    = port_wr[win_idx];
          ctl_addr_d  = port_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          ctl_wdata_d = port_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef SDRAM_ARB_PRIO0_EN
          if (win_idx != '0) last_d = win_idx;
`else
          last_d = win_idx;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ctl_ack) begin
          port_rdata_d = ctl_rdata;
          ctl_req_d    = 1'b0;
          port_ack_d   = grant_q;
          state_d      = ACK;
        end
      end
      ACK: begin
        port_ack_d = '0;
        grant_d    = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(NPORTS-1);
      grant_q      <= '0;
      port_ack_q   <= '0;
      port_rdata_q <= '0;
      ctl_req_q    <= 1'b0;
      ctl_wr_q     <= 1'b0;
      ctl_addr_q   <= '0;
      ctl_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      port_ack_q   <= port_ack_d;
      port_rdata_q <= port_rdata_d;
      ctl_req_q    <= ctl_req_d;
      ctl_wr_q     <= ctl_wr_d;
      ctl_addr_q   <= ctl_addr_d;
      ctl_wdata_q  <= ctl_wdata_d;
    end
  end

  assign port_ack   = port_ack_q;
  assign port_rdata = port_rdata_q;
  assign grant      = grant_q;
  assign ctl_req    = ctl_req_q;
  assign ctl_wr     = ctl_wr_q;
  assign ctl_addr   = ctl_addr_q;
  assign ctl_wdata  = ctl_wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: transaction model plus directed scenarios with literal expectations.
module tb_sdram_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 25;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset_in;
  logic [NP-1:0]   port_req, port_wr, port_ack, grant;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_wdata;
  logic [DW-1:0]   port_rdata, ctl_wdata, ctl_rdata;
  logic [AW-1:0]   ctl_addr;
  logic            ctl_req, ctl_wr, ctl_ack;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .port_req   (port_req),
    .port_wr    (port_wr),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .port_ack   (port_ack),
    .port_rdata (port_rdata),
    .grant      (grant),
    .ctl_req    (ctl_req),
    .ctl_wr     (ctl_wr),
    .ctl_addr   (ctl_addr),
    .ctl_wdata  (ctl_wdata),
    .ctl_ack    (ctl_ack),
    .ctl_rdata  (ctl_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arbitration rule straight from the description: scan from last+1 with wrap.
  function automatic int pick(input logic [NP-1:0] r, input int lst);
`ifdef SDRAM_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= NP; k++) begin
      int i;
      i = (lst + k) % NP;
`ifdef SDRAM_ARB_PRIO0_EN
      if (i != 0 && r[i]) return i;
`else
      if (r[i]) return i;
`endif
    end
    return -1;
  endfunction

  function automatic int next_last(input int p, input int lst);
`ifdef SDRAM_ARB_PRIO0_EN
    return (p == 0) ? lst : p;
`else
    return p;
`endif
  endfunction

  function automatic int oh_idx(input logic [NP-1:0] oh);
    for (int i = 0; i < NP; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Transaction-level model: owner (-1 = none), whether the ack cycle is in flight.
  int            m_owner, m_last;
  bit            m_in_ack;
  logic [NP-1:0] e_grant, e_ack;
  logic          e_req, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset_in) begin
      m_owner <= -1; m_in_ack <= 1'b0; m_last <= NP-1;
      e_grant <= '0; e_ack <= '0; e_req <= 1'b0; e_wr <= 1'b0;
      e_addr <= '0; e_wdata <= '0; e_rdata <= '0;
    end else if (m_in_ack) begin
      m_in_ack <= 1'b0; m_owner <= -1; e_ack <= '0; e_grant <= '0;
    end else if (m_owner >= 0) begin
      if (ctl_ack) begin
        e_rdata <= ctl_rdata; e_req <= 1'b0; m_in_ack <= 1'b1;
        e_ack <= NP'(1) << m_owner;
      end
    end else if (pick(port_req, m_last) >= 0) begin
      m_owner <= pick(port_req, m_last);
      m_last  <= next_last(pick(port_req, m_last), m_last);
      e_grant <= NP'(1) << pick(port_req, m_last);
      e_req   <= 1'b1;
      e_wr    <= port_wr[pick(port_req, m_last)];
      e_addr  <= port_addr[pick(port_req, m_last)*AW +: AW];
      e_wdata <= port_wdata[pick(port_req, m_last)*DW +: DW];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_grant", grant, e_grant);
      chk("m_port_ack", port_ack, e_ack);
      chk("m_port_rdata", port_rdata, e_rdata);
      chk("m_ctl_req", ctl_req, e_req);
      chk("m_ctl_wr", ctl_wr, e_wr);
      chk("m_ctl_addr", ctl_addr, e_addr);
      chk("m_ctl_wdata", ctl_wdata, e_wdata);
    end
  end

  // Controller: acks `lat` cycles into ctl_req; `spur` forces stray acks.
  int            lat = 1;
  bit            spur = 1'b0;
  logic [DW-1:0] rd_val = '0;
  initial begin
    int cnt;
    cnt = 0; ctl_ack = 1'b0; ctl_rdata = '0;
    forever begin
      @(negedge clk);
      if (ctl_req) cnt++; else cnt = 0;
      ctl_ack   = spur || (ctl_req && cnt == lat);
      ctl_rdata = ctl_ack ? rd_val : 16'hDEAD;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input int p, input int budget, output int n);
    n = 0;
    while (!port_ack[p] && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!port_ack[p]) begin
      errors++;
      $display("FAIL wait_ack%0d: no port_ack within %0d cycles, required a pulse", p, budget);
    end
  endtask

  int glog[$];
  task automatic collect(input int count, input int budget);
    logic [NP-1:0] prev;
    int n;
    glog.delete();
    prev = grant; n = 0;
    while (glog.size() < count && n < budget) begin
      @(negedge clk);
      n++;
      if (grant != '0 && prev == '0) glog.push_back(oh_idx(grant));
      prev = grant;
    end
    chk("collect_count", glog.size(), count);
  endtask

  initial begin
    int n;
    int exp3[6];
    int exp4[4];
`ifdef SDRAM_ARB_PRIO0_EN
    exp3 = '{0, 0, 0, 0, 0, 0};
    exp4 = '{0, 0, 0, 0};
`else
    exp3 = '{0, 1, 2, 0, 1, 2};
    exp4 = '{0, 2, 0, 2};
`endif
    reset_in = 1'b1; port_req = '0; port_wr = '0; port_addr = '0; port_wdata = '0;
    cyc(3);
    chk_en = 1'b1;
    chk("rst_grant", grant, 0);
    chk("rst_ctl_req", ctl_req, 0);
    chk("rst_port_ack", port_ack, 0);
    chk("rst_ctl_addr", ctl_addr, 0);
    reset_in = 1'b0;

    // Port 1 write, controller latency 4
    lat = 4;
    port_wr[1] = 1'b1;
    port_addr[1*AW +: AW] = 25'h0000123;
    port_wdata[1*DW +: DW] = 16'hA5A5;
    port_req = 3'b010;
    cyc(1);
    chk("t1_grant", grant, 3'b010);
    chk("t1_ctl_req", ctl_req, 1);
    chk("t1_ctl_wr", ctl_wr, 1);
    chk("t1_ctl_addr", ctl_addr, 25'h0000123);
    chk("t1_ctl_wdata", ctl_wdata, 16'hA5A5);
    wait_ack(1, 20, n);
    chk("t1_ack_delay", n, 4);
    chk("t1_ctl_req_low", ctl_req, 0);
    port_req = '0;
    cyc(1);
    chk("t1_ack_clear", port_ack, 0);
    chk("t1_idle_grant", grant, 0);

    // Port 2 read returns data
    lat = 2; rd_val = 16'h5AC3; port_wr = '0;
    port_addr[2*AW +: AW] = 25'h1ABCDEF;
    port_req = 3'b100;
    wait_ack(2, 20, n);
    chk("t2_port_ack", port_ack, 3'b100);
    chk("t2_rdata", port_rdata, 16'h5AC3);
    port_req = '0;
    cyc(2);

    // Stray controller acks while idle
    spur = 1'b1;
    cyc(2);
    spur = 1'b0;
    cyc(1);
    chk("spur_grant", grant, 0);
    chk("spur_port_ack", port_ack, 0);

    // All ports continuously requesting, immediate ack
    lat = 1; rd_val = 16'h1111;
    port_req = 3'b111;
    collect(6, 60);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), (i < glog.size()) ? glog[i] : -1, exp3[i]);
    port_req = '0;
    cyc(6);

    // Ports 0 and 2 continuously requesting, then port 0 releases
    port_req = 3'b101;
    collect(4, 40);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_grant%0d", i), (i < glog.size()) ? glog[i] : -1, exp4[i]);
    wait_ack(0, 20, n);
    port_req = 3'b100;
    collect(1, 20);
    chk("t4_release", (glog.size() > 0) ? glog[0] : -1, 2);
    wait_ack(2, 20, n);
    port_req = '0;
    cyc(2);

    // Owner drops its request mid-transaction
    lat = 4; rd_val = 16'h7E57;
    port_req = 3'b001;
    cyc(1);
    chk("t5_grant", grant, 3'b001);
    cyc(1);
    port_req = '0;
    cyc(1);
    chk("t5_ctl_req_held", ctl_req, 1);
    wait_ack(0, 20, n);
    chk("t5_port_ack", port_ack, 3'b001);
    cyc(2);

    // Reset while busy abandons the transaction
    lat = 10;
    port_req = 3'b010;
    cyc(3);
    chk("t6_busy", ctl_req, 1);
    reset_in = 1'b1;
    cyc(1);
    reset_in = 1'b0;
    port_req = 3'b011;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_ctl_req", ctl_req, 0);
    chk("t6_rst_port_ack", port_ack, 0);
    chk("t6_rst_ctl_addr", ctl_addr, 0);
    cyc(1);
    chk("t6_first_grant", grant, 3'b001);
    wait_ack(0, 30, n);
    port_req = 3'b010;
    wait_ack(1, 40, n);
    port_req = '0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
